// File: rtl/bitonic_s12_loader_if.sv
// Stream bundle between the serial sample source, the stage-1/2 loader and the stage-3 merger.
interface bitonic_s12_loader_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] number_out1;
  logic [WIDTH-1:0] number_out2;
  logic [WIDTH-1:0] number_out3;
  logic [WIDTH-1:0] number_out4;
  logic [WIDTH-1:0] number_out5;
  logic [WIDTH-1:0] number_out6;
  logic [WIDTH-1:0] number_out7;
  logic [WIDTH-1:0] number_out8;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, busy,
    input  number_out1, number_out2, number_out3, number_out4,
    input  number_out5, number_out6, number_out7, number_out8
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, busy,
    output number_out1, number_out2, number_out3, number_out4,
    output number_out5, number_out6, number_out7, number_out8
  );
endinterface

// File: rtl/bitonic_s12_loader.sv
// Collects 8 serial samples, runs bitonic stages 1 and 2, and holds the resulting
// bitonic vector (1-4 descending, 5-8 ascending) until the merge stage takes it.
//
// state   | meaning
// COLLECT | accepting samples into data_q[cnt]
// ST1     | stage-1 compare-swap layer registered into s1_q
// ST2     | stage-2 (two layers) registered into s2_q
// HOLD    | vector presented, waiting for out_ready
module bitonic_s12_loader #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bitonic_s12_loader_if.slave bus
);

  typedef enum logic [1:0] {COLLECT, ST1, ST2, HOLD} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             wr_en;
  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] s1_q   [8];
  logic [WIDTH-1:0] s2_q   [8];
  logic [WIDTH-1:0] s1_d   [8];
  logic [WIDTH-1:0] la     [8];
  logic [WIDTH-1:0] s2_d   [8];

  function automatic logic [WIDTH-1:0] vmax(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  function automatic logic [WIDTH-1:0] vmin(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a >= b) ? b : a;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST1;
        end
      end
      ST1:     state_d = ST2;
      ST2:     state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Stage 1: adjacent pairs alternate direction so each half of 4 becomes bitonic.
  always_comb begin
    s1_d[0] = vmax(data_q[0], data_q[1]);
    s1_d[1] = vmin(data_q[0], data_q[1]);
    s1_d[2] = vmin(data_q[2], data_q[3]);
    s1_d[3] = vmax(data_q[2], data_q[3]);
    s1_d[4] = vmax(data_q[4], data_q[5]);
    s1_d[5] = vmin(data_q[4], data_q[5]);
    s1_d[6] = vmin(data_q[6], data_q[7]);
    s1_d[7] = vmax(data_q[6], data_q[7]);
  end

  // Stage 2: merge each bitonic half, upper half descending, lower half ascending.
  always_comb begin
    la[0]   = vmax(s1_q[0], s1_q[2]);
    la[2]   = vmin(s1_q[0], s1_q[2]);
    la[1]   = vmax(s1_q[1], s1_q[3]);
    la[3]   = vmin(s1_q[1], s1_q[3]);
    la[4]   = vmin(s1_q[4], s1_q[6]);
    la[6]   = vmax(s1_q[4], s1_q[6]);
    la[5]   = vmin(s1_q[5], s1_q[7]);
    la[7]   = vmax(s1_q[5], s1_q[7]);
    s2_d[0] = vmax(la[0], la[1]);
    s2_d[1] = vmin(la[0], la[1]);
    s2_d[2] = vmax(la[2], la[3]);
    s2_d[3] = vmin(la[2], la[3]);
    s2_d[4] = vmin(la[4], la[5]);
    s2_d[5] = vmax(la[4], la[5]);
    s2_d[6] = vmin(la[6], la[7]);
    s2_d[7] = vmax(la[6], la[7]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= '0;
        s1_q[i]   <= '0;
        s2_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_en)            data_q[cnt_q] <= bus.in_data;
      if (state_q == ST1)   s1_q <= s1_d;
      if (state_q == ST2)   s2_q <= s2_d;
    end
  end

  // Handshake outputs are pure state decodes so no path exists from in_valid/out_ready.
  assign bus.in_ready    = (state_q == COLLECT);
  assign bus.out_valid   = (state_q == HOLD);
  assign bus.busy        = !((state_q == COLLECT) && (cnt_q == 3'd0));
  assign bus.number_out1 = s2_q[0];
  assign bus.number_out2 = s2_q[1];
  assign bus.number_out3 = s2_q[2];
  assign bus.number_out4 = s2_q[3];
  assign bus.number_out5 = s2_q[4];
  assign bus.number_out6 = s2_q[5];
  assign bus.number_out7 = s2_q[6];
  assign bus.number_out8 = s2_q[7];

endmodule

// File: tb/tb_bitonic_s12_loader.sv
// Directed and randomized checks of the stage-1/2 loader against a sort-based reference.
module tb_bitonic_s12_loader;

  typedef logic [7:0] vec_t [8];

  logic clk;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;

  bitonic_s12_loader_if #(.WIDTH(8)) bus ();

  bitonic_s12_loader #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stages 1 and 2 fully sort each half: first four descending, last four ascending.
  task automatic model(input vec_t v, output vec_t r);
    logic [7:0] t;
    r = v;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (r[j] > r[i]) begin t = r[i]; r[i] = r[j]; r[j] = t; end
    for (int i = 4; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (r[j] < r[i]) begin t = r[i]; r[i] = r[j]; r[j] = t; end
  endtask

  task automatic read_out(output vec_t o);
    o[0] = bus.number_out1; o[1] = bus.number_out2;
    o[2] = bus.number_out3; o[3] = bus.number_out4;
    o[4] = bus.number_out5; o[5] = bus.number_out6;
    o[6] = bus.number_out7; o[7] = bus.number_out8;
  endtask

  task automatic check_vec(input string tag, input vec_t exp);
    vec_t o;
    read_out(o);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_out%0d", tag, k + 1), {24'd0, o[k]}, {24'd0, exp[k]});
  endtask

  task automatic send_vec(input vec_t v, input int gap);
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v[k];
      tick();
      bus.in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_hold(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_hold_reached"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  initial begin
    vec_t v, e, m;
    logic [7:0] pend[$];
    logic [7:0] expq[$];
    int nvec;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    e = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    check_vec("rst", e);
    #2 rst_n = 1'b1;
    tick();

    // T1: back-to-back, latency and single-cycle valid
    bus.out_ready = 1'b1;
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    bus.in_valid = 1'b1; bus.in_data = v[0];
    tick();
    chk("t1_busy_after_first", {31'd0, bus.busy}, 32'd1);
    for (int k = 1; k < 8; k++) begin
      bus.in_data = v[k];
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t1_valid_T", {31'd0, bus.out_valid}, 32'd0);
    chk("t1_ready_ST1", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("t1_valid_T1", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("t1_valid_T2", {31'd0, bus.out_valid}, 32'd1);
    e = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd5, 8'd6, 8'd7, 8'd8};
    check_vec("t1", e);
    tick();
    chk("t1_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    chk("t1_ready_back", {31'd0, bus.in_ready},  32'd1);
    chk("t1_busy_idle",  {31'd0, bus.busy},      32'd0);

    // T2: ties
    v = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    send_vec(v, 0);
    wait_hold("t2a");
    check_vec("t2a", v);
    tick();
    v = '{8'd8, 8'd8, 8'd1, 8'd1, 8'd8, 8'd8, 8'd1, 8'd1};
    send_vec(v, 0);
    wait_hold("t2b");
    e = '{8'd8, 8'd8, 8'd1, 8'd1, 8'd1, 8'd1, 8'd8, 8'd8};
    check_vec("t2b", e);
    tick();

    // T3: backpressure with in_valid pulsing during HOLD
    bus.out_ready = 1'b0;
    v = '{8'd10, 8'd200, 8'd33, 8'd7, 8'd150, 8'd0, 8'd99, 8'd42};
    model(v, e);
    send_vec(v, 0);
    wait_hold("t3");
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = c[0] ? 1'b0 : 1'b1;
      bus.in_data  = 8'hFF;
      tick();
      chk($sformatf("t3_valid_c%0d", c), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("t3_ready_c%0d", c), {31'd0, bus.in_ready},  32'd0);
      check_vec($sformatf("t3_c%0d", c), e);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("t3_valid_release", {31'd0, bus.out_valid}, 32'd0);
    chk("t3_ready_release", {31'd0, bus.in_ready},  32'd1);
    chk("t3_busy_release",  {31'd0, bus.busy},      32'd0);
    v = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd4, 8'd3, 8'd2, 8'd1};
    model(v, e);
    send_vec(v, 0);
    wait_hold("t3_after");
    check_vec("t3_after", e);
    tick();

    // T4: gaps between samples
    v = '{8'd9, 8'd7, 8'd5, 8'd3, 8'd2, 8'd4, 8'd6, 8'd8};
    send_vec(v, 2);
    wait_hold("t4");
    check_vec("t4", v);
    tick();

    // T5: reset after 5 transfers, then during HOLD
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(50 + k);
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5a_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t5a_ready", {31'd0, bus.in_ready},  32'd1);
    chk("t5a_busy",  {31'd0, bus.busy},      32'd0);
    e = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    check_vec("t5a_zero", e);
    #2 rst_n = 1'b1;
    tick();
    v = '{8'd1, 8'd3, 8'd2, 8'd4, 8'd11, 8'd13, 8'd12, 8'd14};
    model(v, m);
    send_vec(v, 0);
    wait_hold("t5a_fresh");
    check_vec("t5a_fresh", m);
    bus.out_ready = 1'b0;
    tick();
    chk("t5b_held", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5b_valid", {31'd0, bus.out_valid}, 32'd0);
    check_vec("t5b_zero", e);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    v = '{8'd250, 8'd17, 8'd17, 8'd90, 8'd3, 8'd128, 8'd64, 8'd255};
    model(v, m);
    send_vec(v, 0);
    wait_hold("t5b_fresh");
    check_vec("t5b_fresh", m);
    tick();

    // T6: random traffic with random gaps against the sort-based model
    nvec = 0;
    for (int cyc = 0; cyc < 60000 && nvec < 1000; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.in_valid && bus.in_ready) begin
        pend.push_back(bus.in_data);
        if (pend.size() == 8) begin
          for (int k = 0; k < 8; k++) v[k] = pend[k];
          model(v, m);
          for (int k = 0; k < 8; k++) expq.push_back(m[k]);
          pend.delete();
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("t6_expected_pending", {31'd0, (expq.size() >= 8)}, 32'd1);
        if (expq.size() >= 8) begin
          for (int k = 0; k < 8; k++) m[k] = expq.pop_front();
          check_vec($sformatf("t6_v%0d", nvec), m);
        end
        nvec++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t6_vector_count", nvec, 32'd1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
